// File: rtl/fpcmp_mc.sv
// ---------------------------------------------------------------------------
// fpcmp_mc -- multi-cycle IEEE-754 single-precision comparator
//
// Captures pred/x/y when run is seen in IDLE, holds stall high for LAT cycles,
// then drops stall for exactly one DONE cycle while z/flags are valid.
// z/flags keep their value until the next operation completes.
//
// Parameters:
//   LAT    cycles stall is asserted per operation (2..15)
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   run    operation request, held by the controller until it samples z
//   stall  run & (state != DONE), combinational
//   pred   predicate 0 EQ,1 NE,2 LT,3 LE,4 GT,5 GE,6 UN,7 OR
//   x, y   IEEE single operands
//   z      predicate result (registered)
//   flags  {invalid, divzero, overflow, underflow, inexact} (registered)
//
// Optional build macro:
//   FPCMP_MC_DAZ_EN  denormal operands are treated as signed zeros
// ---------------------------------------------------------------------------
module fpcmp_mc #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        stall,
  input  logic [2:0]  pred,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        z,
  output logic [4:0]  flags
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t     state;
  logic [3:0] count;

  // Captured operand information (stage-1 registers)
  logic [2:0] pred_reg;
  logic       nan_x_reg, nan_y_reg;
  logic       snan_x_reg, snan_y_reg;
  logic       zero_x_reg, zero_y_reg;
  logic       sign_x_reg, sign_y_reg;
  logic       mag_lt_reg, mag_eq_reg;

  // Magnitudes used for ordering; with DAZ a denormal collapses to zero
  logic [30:0] mag_x, mag_y;
`ifdef FPCMP_MC_DAZ_EN
  assign mag_x = (x[30:23] == 8'h00) ? 31'd0 : x[30:0];
  assign mag_y = (y[30:23] == 8'h00) ? 31'd0 : y[30:0];
`else
  assign mag_x = x[30:0];
  assign mag_y = y[30:0];
`endif

  logic nan_x, nan_y, snan_x, snan_y;
  assign nan_x  = (&x[30:23]) & (|x[22:0]);
  assign nan_y  = (&y[30:23]) & (|y[22:0]);
  // Signalling NaN: quiet bit (frac[22]) clear
  assign snan_x = nan_x & ~x[22];
  assign snan_y = nan_y & ~y[22];

  assign stall = run & (state != DONE);

  // Stage 2: predicate evaluation from the captured classification
  logic unordered, both_zero, ord_eq, ord_lt, ord_gt;
  logic z_next, invalid_next;

  always_comb begin
    unordered = nan_x_reg | nan_y_reg;
    both_zero = zero_x_reg & zero_y_reg;
    ord_eq    = both_zero | ((sign_x_reg == sign_y_reg) & mag_eq_reg);
    ord_lt    = 1'b0;
    if (!both_zero) begin
      if (sign_x_reg != sign_y_reg)
        ord_lt = sign_x_reg;                     // negative operand is less
      else if (!sign_x_reg)
        ord_lt = mag_lt_reg;                     // both positive
      else
        ord_lt = ~mag_lt_reg & ~mag_eq_reg;      // both negative: reversed
    end
    ord_gt = ~ord_lt & ~ord_eq;

    z_next = 1'b0;
    if (unordered) begin
      z_next = (pred_reg == 3'd1) | (pred_reg == 3'd6);
    end else begin
      case (pred_reg)
        3'd0:    z_next = ord_eq;
        3'd1:    z_next = ~ord_eq;
        3'd2:    z_next = ord_lt;
        3'd3:    z_next = ord_lt | ord_eq;
        3'd4:    z_next = ord_gt;
        3'd5:    z_next = ord_gt | ord_eq;
        3'd6:    z_next = 1'b0;
        default: z_next = 1'b1;
      endcase
    end

    // Ordering predicates signal on any NaN; the rest only on sNaN
    invalid_next = snan_x_reg | snan_y_reg |
                   (unordered & (pred_reg >= 3'd2) & (pred_reg <= 3'd5));
  end

  // Classification happens on the capture edge so the stage-1 registers are
  // already valid in the first BUSY cycle; this is what lets LAT=2 finish
  // with a single BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= 4'd0;
      z          <= 1'b0;
      flags      <= 5'b00000;
      pred_reg   <= 3'd0;
      nan_x_reg  <= 1'b0;
      nan_y_reg  <= 1'b0;
      snan_x_reg <= 1'b0;
      snan_y_reg <= 1'b0;
      zero_x_reg <= 1'b0;
      zero_y_reg <= 1'b0;
      sign_x_reg <= 1'b0;
      sign_y_reg <= 1'b0;
      mag_lt_reg <= 1'b0;
      mag_eq_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            pred_reg   <= pred;
            nan_x_reg  <= nan_x;
            nan_y_reg  <= nan_y;
            snan_x_reg <= snan_x;
            snan_y_reg <= snan_y;
            zero_x_reg <= (mag_x == 31'd0);
            zero_y_reg <= (mag_y == 31'd0);
            sign_x_reg <= x[31];
            sign_y_reg <= y[31];
            mag_lt_reg <= (mag_x < mag_y);
            mag_eq_reg <= (mag_x == mag_y);
            count      <= LAT_M1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          count <= count - 4'd1;
          if (count <= 4'd1) begin
            z     <= z_next;
            flags <= {invalid_next, 4'b0000};
            state <= DONE;
          end
        end
        DONE: begin
          count <= 4'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpcmp_mc.sv
// ---------------------------------------------------------------------------
// tb_fpcmp_mc -- self-checking bench for fpcmp_mc
//
// Two instances (LAT=2 and LAT=5) share operands and reset but have their
// own run lines. Expected z/flags come from a real-number reference model.
// ---------------------------------------------------------------------------
module tb_fpcmp_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run2, run5;
  logic [2:0]  pred;
  logic [31:0] x, y;
  logic        stall2, stall5, z2, z5;
  logic [4:0]  flags2, flags5;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  fpcmp_mc #(.LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2), .stall(stall2),
    .pred(pred), .x(x), .y(y), .z(z2), .flags(flags2)
  );

  fpcmp_mc #(.LAT(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .run(run5), .stall(stall5),
    .pred(pred), .x(x), .y(y), .z(z5), .flags(flags5)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real to_real(input logic [31:0] b);
    int  e;
    real m, v;
    e = int'(b[30:23]);
    m = real'(b[22:0]);
    if (e == 255)
      v = 1.0e300;
    else if (e == 0) begin
`ifdef FPCMP_MC_DAZ_EN
      v = 0.0;
`else
      v = m * (2.0 ** (-149.0));
`endif
    end else
      v = (m + 8388608.0) * (2.0 ** real'(e - 150));
    return b[31] ? -v : v;
  endfunction

  function automatic logic is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  // returns {z, flags[4:0]}
  function automatic logic [5:0] model(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b);
    logic un, sn, zz, inv;
    real  ra, rb;
    un = is_nan(a) || is_nan(b);
    sn = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
    ra = to_real(a);
    rb = to_real(b);
    case (p)
      3'd0: zz = !un && (ra == rb);
      3'd1: zz = un || (ra != rb);
      3'd2: zz = !un && (ra < rb);
      3'd3: zz = !un && (ra <= rb);
      3'd4: zz = !un && (ra > rb);
      3'd5: zz = !un && (ra >= rb);
      3'd6: zz = un;
      default: zz = !un;
    endcase
    inv = sn || (un && p >= 3'd2 && p <= 3'd5);
    return {zz, inv, 4'b0000};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Entered at a falling edge with run already high for the selected DUT.
  // Measures stall width, checks result, drops run, checks hold.
  task automatic measure(input int dsel, input logic [5:0] exp, input string tag);
    int   w;
    int   lat;
    logic st, zz;
    logic [4:0] ff;
    w   = -1;
    lat = (dsel == 2) ? 2 : 5;
    zz  = 1'b0;
    ff  = 5'd0;
    for (int k = 0; k < 40; k++) begin
      #1;
      st = (dsel == 2) ? stall2 : stall5;
      if (!st) begin
        w  = k;
        zz = (dsel == 2) ? z2 : z5;
        ff = (dsel == 2) ? flags2 : flags5;
        break;
      end
      if (k == 1) begin
        // operands change after capture and must be ignored
        x    = $urandom;
        y    = $urandom;
        pred = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    if (dsel == 2) run2 = 1'b0; else run5 = 1'b0;
    check_eq({tag, " width"}, 32'(w), 32'(lat));
    check_eq({tag, " z"}, {31'd0, zz}, {31'd0, exp[5]});
    check_eq({tag, " flags"}, {27'd0, ff}, {27'd0, exp[4:0]});
    $display("[TB] %s lat=%0d width=%0d z=%0b flags=%02h", tag, lat, w, zz, ff);
    @(negedge clk);
    @(negedge clk);
    #1;
    zz = (dsel == 2) ? z2 : z5;
    check_eq({tag, " hold"}, {31'd0, zz}, {31'd0, exp[5]});
  endtask

  task automatic run_op(input int dsel, input logic [2:0] p, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [5:0] exp;
    exp = model(p, a, b);
    @(negedge clk);
    pred = p;
    x    = a;
    y    = b;
    if (dsel == 2) run2 = 1'b1; else run5 = 1'b1;
    measure(dsel, exp, tag);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] sp [12];
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 32'h7F800001, 32'hFFA00000, 32'h00000001,
           32'h80000001, 32'h3F800000, 32'hBF800000, 32'h007FFFFF};
    if ($urandom_range(0, 1) == 0)
      return sp[$urandom_range(0, 11)];
    return $urandom;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0]  exp;
    logic [31:0] a, b;
    rst_n = 1'b0;
    run2  = 1'b0;
    run5  = 1'b0;
    pred  = 3'd0;
    x     = 32'd0;
    y     = 32'd0;
    repeat (2) @(negedge clk);
    run2 = 1'b1;
    #1;
    check_eq("reset z2", {31'd0, z2}, 32'd0);
    check_eq("reset flags2", {27'd0, flags2}, 32'd0);
    check_eq("reset z5", {31'd0, z5}, 32'd0);
    check_eq("reset flags5", {27'd0, flags5}, 32'd0);
    check_eq("reset stall=run", {31'd0, stall2}, 32'd1);
    run2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_op(2, 3'd2, 32'h3F800000, 32'h40000000, "lt_1_2");
    run_op(2, 3'd0, 32'h00000000, 32'h80000000, "eq_pz_nz");
    run_op(2, 3'd4, 32'h00000000, 32'h80000000, "gt_pz_nz");
    run_op(2, 3'd2, 32'h7FC00000, 32'h3F800000, "lt_qnan");
    run_op(2, 3'd0, 32'h7FC00000, 32'h3F800000, "eq_qnan");
    run_op(2, 3'd6, 32'h7FC00000, 32'h3F800000, "un_qnan");
    run_op(2, 3'd1, 32'h7F800001, 32'h7F800001, "ne_snan");
    run_op(2, 3'd5, 32'hFF800000, 32'h7F800000, "ge_ninf_pinf");
    run_op(2, 3'd0, 32'h00000001, 32'h80000000, "eq_denorm");
    run_op(5, 3'd2, 32'h3F800000, 32'h40000000, "lt_1_2_l5");
    run_op(5, 3'd0, 32'h00000001, 32'h80000000, "eq_denorm_l5");

    // reset in the second BUSY cycle of a LAT=5 op
    run_op(5, 3'd3, 32'hC0000000, 32'hBF800000, "le_neg");
    exp = model(3'd2, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    pred = 3'd2;
    x    = 32'h3F800000;
    y    = 32'h40000000;
    run5 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst z5", {31'd0, z5}, 32'd0);
    check_eq("midrst flags5", {27'd0, flags5}, 32'd0);
    check_eq("midrst stall5", {31'd0, stall5}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    measure(5, exp, "post_reset");

    // run dropped mid-operation: z=1 from before, new result is 0
    exp = model(3'd4, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    pred = 3'd4;
    x    = 32'h3F800000;
    y    = 32'h40000000;
    run5 = 1'b1;
    #1;
    check_eq("drop stall c0", {31'd0, stall5}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    run5 = 1'b0;
    #1;
    check_eq("drop stall c2", {31'd0, stall5}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("drop z c4 old", {31'd0, z5}, 32'd1);
    @(negedge clk);
    #1;
    check_eq("drop z c5", {31'd0, z5}, {31'd0, exp[5]});
    check_eq("drop flags c5", {27'd0, flags5}, {27'd0, exp[4:0]});
    $display("[TB] run_drop z=%0b flags=%02h", z5, flags5);

    // randomized operations
    for (int i = 0; i < 150; i++) begin
      a = pick_operand();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h80000000;
        default: b = pick_operand();
      endcase
      run_op(($urandom_range(0, 1) == 0) ? 2 : 5, 3'($urandom_range(0, 7)), a, b, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
